// File: rtl/traffic_ctrl.sv
// Intersection controller: sequences main-street, side-street and pedestrian lamps
// on a tick derived from clk by a free-running prescaler.
//
// Ports:
//   clk          system clock
//   arst_i       asynchronous active-high reset
//   walk_en_i    debounced walk request (level or pulse)
//   sensor_i     side-street car sensor, synchronous to clk
//   main_lamp_o  main street lamps {red,yellow,green}, one-hot
//   side_lamp_o  side street lamps {red,yellow,green}, one-hot
//   walk_lamp_o  pedestrian walk lamp
//   state_o      current state encoding
//   sec_left_o   ticks remaining in the current state (15..1)
module traffic_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned T_MAIN_G = 6,
  parameter int unsigned T_SIDE_G = 6,
  parameter int unsigned T_EXT    = 3,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_WALK   = 3
) (
  input  logic       clk,
  input  logic       arst_i,
  input  logic       walk_en_i,
  input  logic       sensor_i,
  output logic [2:0] main_lamp_o,
  output logic [2:0] side_lamp_o,
  output logic       walk_lamp_o,
  output logic [2:0] state_o,
  output logic [3:0] sec_left_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    StMainG   = 3'd0,
    StMainY   = 3'd1,
    StWalk    = 3'd2,
    StSideG   = 3'd3,
    StSideExt = 3'd4,
    StSideY   = 3'd5
  } state_e;

  localparam logic [2:0] LampR = 3'b100;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampG = 3'b001;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      sec_q, sec_d;
  logic            walk_req_q, walk_req_d;
  logic            sens_seen_q, sens_seen_d;
  logic [2:0]      main_lamp_q, side_lamp_q;
  logic            walk_lamp_q;
  logic [6:0]      lamps_d;
  logic            tick;
  state_e          nxt;
  logic            illegal;

  function automatic logic [3:0] dur(input state_e s);
    case (s)
      StMainG:   dur = 4'(T_MAIN_G);
      StMainY:   dur = 4'(T_YEL);
      StWalk:    dur = 4'(T_WALK);
      StSideG:   dur = 4'(T_SIDE_G);
      StSideExt: dur = 4'(T_EXT);
      StSideY:   dur = 4'(T_YEL);
      default:   dur = 4'(T_MAIN_G);
    endcase
  endfunction

  // {main, side, walk}
  function automatic logic [6:0] lamps(input state_e s);
    case (s)
      StMainG:   lamps = {LampG, LampR, 1'b0};
      StMainY:   lamps = {LampY, LampR, 1'b0};
      StWalk:    lamps = {LampR, LampR, 1'b1};
      StSideG:   lamps = {LampR, LampG, 1'b0};
      StSideExt: lamps = {LampR, LampG, 1'b0};
      StSideY:   lamps = {LampR, LampY, 1'b0};
      default:   lamps = {LampG, LampR, 1'b0};
    endcase
  endfunction

  always_comb begin
    tick        = (presc_q == PW'(TICK_DIV - 1));
    presc_d     = tick ? '0 : presc_q + PW'(1);
    state_d     = state_q;
    sec_d       = sec_q;
    walk_req_d  = walk_req_q;
    sens_seen_d = sens_seen_q;
    illegal     = 1'b0;
    nxt         = StMainG;

    case (state_q)
      StMainG:   nxt = StMainY;
      StMainY:   nxt = (walk_req_q || walk_en_i) ? StWalk : StSideG;
      StWalk:    nxt = StSideG;
      StSideG:   nxt = (sens_seen_q || sensor_i) ? StSideExt : StSideY;
      StSideExt: nxt = StSideY;
      StSideY:   nxt = StMainG;
      default:   illegal = 1'b1;
    endcase

    if (illegal) begin
      // Unreachable encodings recover without waiting for a tick.
      state_d = StMainG;
      sec_d   = 4'(T_MAIN_G);
    end else if (tick && sec_q == 4'd1) begin
      state_d = nxt;
      sec_d   = dur(nxt);
    end else if (tick) begin
      sec_d = sec_q - 4'd1;
    end

    // Entry into WALK wins over a coincident press; presses during WALK are dropped.
    if (state_d == StWalk && state_q != StWalk) begin
      walk_req_d = 1'b0;
    end else if (walk_en_i && state_q != StWalk) begin
      walk_req_d = 1'b1;
    end

    if (state_d == StSideG && state_q != StSideG) begin
      sens_seen_d = 1'b0;
    end else if (state_q == StSideG && sensor_i) begin
      sens_seen_d = 1'b1;
    end

    lamps_d = lamps(state_d);
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= StMainG;
      presc_q     <= '0;
      sec_q       <= 4'(T_MAIN_G);
      walk_req_q  <= 1'b0;
      sens_seen_q <= 1'b0;
      main_lamp_q <= LampG;
      side_lamp_q <= LampR;
      walk_lamp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      walk_req_q  <= walk_req_d;
      sens_seen_q <= sens_seen_d;
      main_lamp_q <= lamps_d[6:4];
      side_lamp_q <= lamps_d[3:1];
      walk_lamp_q <= lamps_d[0];
    end
  end

  assign main_lamp_o = main_lamp_q;
  assign side_lamp_o = side_lamp_q;
  assign walk_lamp_o = walk_lamp_q;
  assign state_o     = state_q;
  assign sec_left_o  = sec_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
module tb_traffic_ctrl;

  logic       clk = 1'b0;
  logic       arst_i;
  logic       walk_en_i;
  logic       sensor_i;
  logic [2:0] main_lamp_o;
  logic [2:0] side_lamp_o;
  logic       walk_lamp_o;
  logic [2:0] state_o;
  logic [3:0] sec_left_o;

  int total = 0;
  int bad   = 0;

  traffic_ctrl #(
    .TICK_DIV(4),
    .T_MAIN_G(6),
    .T_SIDE_G(6),
    .T_EXT   (3),
    .T_YEL   (2),
    .T_WALK  (3)
  ) dut (
    .clk        (clk),
    .arst_i     (arst_i),
    .walk_en_i  (walk_en_i),
    .sensor_i   (sensor_i),
    .main_lamp_o(main_lamp_o),
    .side_lamp_o(side_lamp_o),
    .walk_lamp_o(walk_lamp_o),
    .state_o    (state_o),
    .sec_left_o (sec_left_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct {
    int         wait_cyc;
    logic       walk;
    logic       sens;
    logic [2:0] st;
    logic [2:0] main;
    logic [2:0] side;
    logic       wl;
    logic [3:0] sec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int w, input logic wk, input logic sn, input logic [2:0] st,
                     input logic [2:0] m, input logic [2:0] s, input logic wl,
                     input logic [3:0] sec);
    vec_t v;
    v.wait_cyc = w; v.walk = wk; v.sens = sn; v.st = st;
    v.main = m; v.side = s; v.wl = wl; v.sec = sec;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [2:0] m,
                       input logic [2:0] s, input logic wl, input logic [3:0] sec);
    total++;
    if ({state_o, main_lamp_o, side_lamp_o, walk_lamp_o, sec_left_o} !== {st, m, s, wl, sec}) begin
      bad++;
      $display("FAIL %s: got st=%0d main=%b side=%b walk=%b sec=%0d, want st=%0d main=%b side=%b walk=%b sec=%0d",
               name, state_o, main_lamp_o, side_lamp_o, walk_lamp_o, sec_left_o,
               st, m, s, wl, sec);
    end
  endtask

  // Lamp safety invariant every cycle.
  always @(negedge clk) begin
    total++;
    if (!$onehot(main_lamp_o) || !$onehot(side_lamp_o) ||
        (main_lamp_o[1:0] != 2'b00 && side_lamp_o[1:0] != 2'b00) ||
        (walk_lamp_o && !(main_lamp_o == R && side_lamp_o == R))) begin
      bad++;
      $display("FAIL safety @%0t: got main=%b side=%b walk=%b, want one-hot, no conflict",
               $time, main_lamp_o, side_lamp_o, walk_lamp_o);
    end
  end

  initial begin
    // Period 1: idle cycle, no inputs.
    add( 1, 0, 0, 3'd0, G, R, 0, 4'd6);
    add( 3, 0, 0, 3'd0, G, R, 0, 4'd5);
    add( 4, 0, 0, 3'd0, G, R, 0, 4'd4);
    add(15, 0, 0, 3'd0, G, R, 0, 4'd1);
    add( 1, 0, 0, 3'd1, Y, R, 0, 4'd2);
    add( 7, 0, 0, 3'd1, Y, R, 0, 4'd1);
    add( 1, 0, 0, 3'd3, R, G, 0, 4'd6);
    add(23, 0, 0, 3'd3, R, G, 0, 4'd1);
    add( 1, 0, 0, 3'd5, R, Y, 0, 4'd2);
    add( 7, 0, 0, 3'd5, R, Y, 0, 4'd1);
    add( 1, 0, 0, 3'd0, G, R, 0, 4'd6);
    // Period 2: press at MAIN_G cycle 5, plus a press coincident with WALK entry.
    add( 5, 0, 0, 3'd0, G, R, 0, 4'd5);
    add( 1, 1, 0, 3'd0, G, R, 0, 4'd5);
    add(18, 0, 0, 3'd1, Y, R, 0, 4'd2);
    add( 7, 0, 0, 3'd1, Y, R, 0, 4'd1);
    add( 1, 1, 0, 3'd2, R, R, 1, 4'd3);
    add(11, 0, 0, 3'd2, R, R, 1, 4'd1);
    add( 1, 0, 0, 3'd3, R, G, 0, 4'd6);
    add(24, 0, 0, 3'd5, R, Y, 0, 4'd2);
    add( 8, 0, 0, 3'd0, G, R, 0, 4'd6);
    // Period 3: coincident press was cleared, so WALK is skipped.
    add(24, 0, 0, 3'd1, Y, R, 0, 4'd2);
    add( 8, 0, 0, 3'd3, R, G, 0, 4'd6);
    add(24, 0, 0, 3'd5, R, Y, 0, 4'd2);
    add( 8, 0, 0, 3'd0, G, R, 0, 4'd6);
    // Period 4: walk serviced, then a press during WALK.
    add( 5, 0, 0, 3'd0, G, R, 0, 4'd5);
    add( 1, 1, 0, 3'd0, G, R, 0, 4'd5);
    add(18, 0, 0, 3'd1, Y, R, 0, 4'd2);
    add( 8, 0, 0, 3'd2, R, R, 1, 4'd3);
    add( 3, 0, 0, 3'd2, R, R, 1, 4'd3);
    add( 1, 1, 0, 3'd2, R, R, 1, 4'd2);
    add( 8, 0, 0, 3'd3, R, G, 0, 4'd6);
    add(24, 0, 0, 3'd5, R, Y, 0, 4'd2);
    add( 8, 0, 0, 3'd0, G, R, 0, 4'd6);
    // Period 5: press during WALK was discarded; sensor pulse mid SIDE_G.
    add(24, 0, 0, 3'd1, Y, R, 0, 4'd2);
    add( 8, 0, 0, 3'd3, R, G, 0, 4'd6);
    add(10, 0, 0, 3'd3, R, G, 0, 4'd4);
    add( 1, 0, 1, 3'd3, R, G, 0, 4'd4);
    add(13, 0, 0, 3'd4, R, G, 0, 4'd3);
    add(11, 0, 1, 3'd4, R, G, 0, 4'd1);
    add( 1, 0, 1, 3'd5, R, Y, 0, 4'd2);
    add( 8, 0, 0, 3'd0, G, R, 0, 4'd6);
    // Period 6: no sensor, extension must not recur.
    add(24, 0, 0, 3'd1, Y, R, 0, 4'd2);
    add( 8, 0, 0, 3'd3, R, G, 0, 4'd6);
    add(24, 0, 0, 3'd5, R, Y, 0, 4'd2);
    add( 8, 0, 0, 3'd0, G, R, 0, 4'd6);
    // Period 7: reach SIDE_EXT with a pending walk request.
    add(24, 0, 0, 3'd1, Y, R, 0, 4'd2);
    add( 8, 0, 0, 3'd3, R, G, 0, 4'd6);
    add( 1, 0, 1, 3'd3, R, G, 0, 4'd6);
    add(23, 0, 0, 3'd4, R, G, 0, 4'd3);
    add( 2, 1, 0, 3'd4, R, G, 0, 4'd3);

    arst_i = 1'b1; walk_en_i = 1'b0; sensor_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 3'd0, G, R, 0, 4'd6);
    arst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      walk_en_i = vecs[i].walk;
      sensor_i  = vecs[i].sens;
      repeat (vecs[i].wait_cyc) @(posedge clk);
      #1;
      walk_en_i = 1'b0;
      sensor_i  = 1'b0;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].main, vecs[i].side, vecs[i].wl,
            vecs[i].sec);
    end

    // Asynchronous reset mid SIDE_EXT: outputs return before any clock edge.
    #3;
    arst_i = 1'b1;
    #1;
    check("async_reset", 3'd0, G, R, 0, 4'd6);
    @(posedge clk);
    #1;
    arst_i = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    check("post_rst_main_g", 3'd0, G, R, 0, 4'd1);
    @(posedge clk);
    #1;
    check("post_rst_main_y", 3'd1, Y, R, 0, 4'd2);
    repeat (8) @(posedge clk);
    #1;
    // Pending walk request was dropped by reset.
    check("post_rst_side_g", 3'd3, R, G, 0, 4'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
